// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, control FSM states, select and trap encodings.
package rv32_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4     = 2'b00,
    PC_ALU       = 2'b01,
    PC_ALU_ALIGN = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  // One-hot opcode class; exactly one bit set for a legal opcode.
  typedef struct packed {
    logic system;
    logic fence;
    logic op;
    logic op_imm;
    logic store;
    logic load;
    logic branch;
    logic jalr;
    logic jal;
    logic auipc;
    logic lui;
  } op_class_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier: one-hot class plus illegal flag.
module mc_opdecode
  import rv32_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        cls,
  output logic             illegal
);

  // Match each legal opcode; anything unmatched is illegal.
  always_comb begin
    cls        = '0;
    cls.lui    = (opcode == OPC_LUI);
    cls.auipc  = (opcode == OPC_AUIPC);
    cls.jal    = (opcode == OPC_JAL);
    cls.jalr   = (opcode == OPC_JALR);
    cls.branch = (opcode == OPC_BRANCH);
    cls.load   = (opcode == OPC_LOAD);
    cls.store  = (opcode == OPC_STORE);
    cls.op_imm = (opcode == OPC_OPIMM);
    cls.op     = (opcode == OPC_OP);
    cls.fence  = (opcode == OPC_FENCE);
    cls.system = (opcode == OPC_SYSTEM);
    illegal    = ~|cls;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I main control: sequences fetch/decode/exec/mem/wb over one memory port.
module mc_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  op_class_t         cls;
  logic              illegal;
  logic              wait_expired;
  logic              exec_a;
  logic              exec_b;
  trap_cause_t       cause_next;
  pc_sel_t           pc_sel_v;
  wb_sel_t           wb_sel_v;
  logic              unused_instr_hi;

  assign unused_instr_hi = ^instr[31:7];

  mc_opdecode u_opdecode (
    .opcode  (instr[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  // ALU operand selects chosen in EXEC and held through MEM/WB.
  assign exec_a = cls.branch | cls.jal | cls.auipc;
  assign exec_b = cls.branch | cls.jal | cls.jalr | cls.load | cls.store
                | cls.op_imm | cls.auipc;

  // Last permitted wait cycle of a memory request with no response.
  assign wait_expired = (TIMEOUT_CYCLES != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

  // Next-state and decoded control outputs; everything is forced low during reset.
  always_comb begin
    next_state = state;
    cause_next = CAUSE_NONE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel_v   = PC_PLUS4;
    rf_we      = 1'b0;
    wb_sel_v   = WB_ALU;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    retire     = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          next_state = ST_DECODE;
        end else if (wait_expired) begin
          next_state = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      ST_DECODE: begin
        if (illegal) begin
          next_state = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          next_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_a_sel = exec_a;
        alu_b_sel = exec_b;
        if (cls.branch) begin
          pc_we      = 1'b1;
          pc_sel_v   = br_taken ? PC_ALU : PC_PLUS4;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (cls.jal || cls.jalr) begin
          pc_we      = 1'b1;
          pc_sel_v   = cls.jal ? PC_ALU : PC_ALU_ALIGN;
          rf_we      = 1'b1;
          wb_sel_v   = WB_PC4;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (cls.fence || cls.system) begin
          pc_we      = 1'b1;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (cls.load || cls.store) begin
          next_state = ST_MEM;
        end else if (cls.op || cls.op_imm || cls.lui || cls.auipc) begin
          next_state = ST_WB;
        end else begin
          next_state = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_we    = cls.store;
        alu_a_sel = exec_a;
        alu_b_sel = exec_b;
        if (mem_ready) begin
          if (cls.store) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else if (wait_expired) begin
          next_state = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      ST_WB: begin
        alu_a_sel  = exec_a;
        alu_b_sel  = exec_b;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        wb_sel_v   = cls.load ? WB_LOAD : (cls.lui ? WB_IMM : WB_ALU);
        next_state = ST_FETCH;
      end

      ST_TRAP: begin
        next_state = ST_TRAP;
      end

      default: begin
        next_state = ST_TRAP;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase

    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel_v  = PC_PLUS4;
      rf_we     = 1'b0;
      wb_sel_v  = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      retire    = 1'b0;
    end
  end

  assign pc_sel  = pc_sel_v;
  assign wb_sel  = wb_sel_v;
  assign state_o = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Memory wait counter: cleared on entering a request state, counts unanswered cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((next_state != state) && ((next_state == ST_FETCH) || (next_state == ST_MEM))) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Retired-instruction counter, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end

  // Sticky trap flag and cause, captured on entry to TRAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else if ((next_state == ST_TRAP) && (state != ST_TRAP)) begin
      trap       <= 1'b1;
      trap_cause <= cause_next;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl with per-scenario cycle tables.
module tb_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        retire;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_instret = 32'd0;

  mc_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .retire(retire), .instret(instret), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed strobes/selects: {req,we,sel,ir_we,pc_we,pc_sel,rf_we,wb_sel,a,b,retire}
  localparam logic [12:0] O_IDLE     = 13'b0_0_0_0_0_00_0_00_0_0_0;
  localparam logic [12:0] O_F        = 13'b1_0_0_1_0_00_0_00_0_0_0;
  localparam logic [12:0] O_FW       = 13'b1_0_0_0_0_00_0_00_0_0_0;
  localparam logic [12:0] O_EX_B     = 13'b0_0_0_0_0_00_0_00_0_1_0;
  localparam logic [12:0] O_WB_OPIMM = 13'b0_0_0_0_1_00_1_00_0_1_1;
  localparam logic [12:0] O_BR_T     = 13'b0_0_0_0_1_01_0_00_1_1_1;
  localparam logic [12:0] O_BR_N     = 13'b0_0_0_0_1_00_0_00_1_1_1;
  localparam logic [12:0] O_MEM_LD   = 13'b1_0_1_0_0_00_0_00_0_1_0;
  localparam logic [12:0] O_WB_LD    = 13'b0_0_0_0_1_00_1_01_0_1_1;
  localparam logic [12:0] O_MEM_SW_W = 13'b1_1_1_0_0_00_0_00_0_1_0;
  localparam logic [12:0] O_MEM_SW   = 13'b1_1_1_0_1_00_0_00_0_1_1;
  localparam logic [12:0] O_JAL      = 13'b0_0_0_0_1_01_1_10_1_1_1;
  localparam logic [12:0] O_JALR     = 13'b0_0_0_0_1_10_1_10_0_1_1;
  localparam logic [12:0] O_WB_LUI   = 13'b0_0_0_0_1_00_1_11_0_0_1;

  localparam logic [31:0] I_ADDI = 32'h00508113;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LW   = 32'h0000a183;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_JAL  = 32'h008000ef;
  localparam logic [31:0] I_JALR = 32'h000080e7;
  localparam logic [31:0] I_LUI  = 32'h123450b7;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        brt;
    logic [2:0]  st;
    logic [12:0] o;
  } cyc_t;

  function automatic logic [12:0] obs();
    return {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
            alu_a_sel, alu_b_sel, retire};
  endfunction

  function automatic cyc_t row(logic [31:0] ins, logic rdy, logic brt, logic [2:0] st,
                               logic [12:0] o);
    cyc_t c;
    c.ins = ins; c.rdy = rdy; c.brt = brt; c.st = st; c.o = o;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = I_ADDI; mem_ready = 1'b1; br_taken = 1'b1;
    tick();
    tick();
    vectors++;
    if (obs() !== O_IDLE) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs(), O_IDLE); end
    vectors++;
    if ({state_o, trap, trap_cause} !== 6'b000_0_00) begin
      errors++; $display("FAIL reset_regs: state %0d trap %0b cause %0d", state_o, trap, trap_cause);
    end
    vectors++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d exp 0", instret); end
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_addi();
    cyc_t q[$];
    q.push_back(row(I_ADDI, 1, 0, 0, O_F));
    q.push_back(row(I_ADDI, 1, 0, 1, O_IDLE));
    q.push_back(row(I_ADDI, 1, 0, 2, O_EX_B));
    q.push_back(row(I_ADDI, 1, 0, 4, O_WB_OPIMM));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL addi_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL addi_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    exp_instret = exp_instret + 32'd1;
    vectors++;
    if (instret !== exp_instret) begin errors++; $display("FAIL addi_instret: got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_branch();
    cyc_t q[$];
    q.push_back(row(I_BEQ, 1, 1, 0, O_F));
    q.push_back(row(I_BEQ, 1, 1, 1, O_IDLE));
    q.push_back(row(I_BEQ, 1, 1, 2, O_BR_T));
    q.push_back(row(I_BEQ, 1, 0, 0, O_F));
    q.push_back(row(I_BEQ, 1, 0, 1, O_IDLE));
    q.push_back(row(I_BEQ, 1, 0, 2, O_BR_N));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL branch_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL branch_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    exp_instret = exp_instret + 32'd2;
    vectors++;
    if (instret !== exp_instret) begin errors++; $display("FAIL branch_instret: got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_load_wait();
    cyc_t q[$];
    q.push_back(row(I_LW, 1, 0, 0, O_F));
    q.push_back(row(I_LW, 1, 0, 1, O_IDLE));
    q.push_back(row(I_LW, 1, 0, 2, O_EX_B));
    q.push_back(row(I_LW, 0, 0, 3, O_MEM_LD));
    q.push_back(row(I_LW, 0, 0, 3, O_MEM_LD));
    q.push_back(row(I_LW, 0, 0, 3, O_MEM_LD));
    q.push_back(row(I_LW, 1, 0, 3, O_MEM_LD));
    q.push_back(row(I_LW, 1, 0, 4, O_WB_LD));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL load_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL load_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    exp_instret = exp_instret + 32'd1;
    vectors++;
    if (state_o !== 3'd0 || instret !== exp_instret) begin
      errors++; $display("FAIL load_end: state %0d instret %0d exp state 0 instret %0d", state_o, instret, exp_instret);
    end
  endtask

  task automatic test_store();
    cyc_t q[$];
    q.push_back(row(I_SW, 1, 0, 0, O_F));
    q.push_back(row(I_SW, 1, 0, 1, O_IDLE));
    q.push_back(row(I_SW, 1, 0, 2, O_EX_B));
    q.push_back(row(I_SW, 1, 0, 3, O_MEM_SW));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL store_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL store_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    exp_instret = exp_instret + 32'd1;
    vectors++;
    if (state_o !== 3'd0 || instret !== exp_instret) begin
      errors++; $display("FAIL store_end: state %0d instret %0d exp state 0 instret %0d", state_o, instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t q[$];
    q.push_back(row(I_JAL,  1, 0, 0, O_F));
    q.push_back(row(I_JAL,  1, 0, 1, O_IDLE));
    q.push_back(row(I_JAL,  1, 0, 2, O_JAL));
    q.push_back(row(I_JALR, 1, 0, 0, O_F));
    q.push_back(row(I_JALR, 1, 0, 1, O_IDLE));
    q.push_back(row(I_JALR, 1, 0, 2, O_JALR));
    q.push_back(row(I_LUI,  1, 0, 0, O_F));
    q.push_back(row(I_LUI,  1, 0, 1, O_IDLE));
    q.push_back(row(I_LUI,  1, 0, 2, O_IDLE));
    q.push_back(row(I_LUI,  1, 0, 4, O_WB_LUI));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL b2b_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL b2b_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    exp_instret = exp_instret + 32'd3;
    vectors++;
    if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret: got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal();
    instr = I_ILL; mem_ready = 1'b1; br_taken = 1'b0; #1;
    vectors++;
    if (state_o !== 3'd0 || obs() !== O_F) begin errors++; $display("FAIL illegal_fetch: state %0d out %b", state_o, obs()); end
    tick();
    vectors++;
    if (state_o !== 3'd1 || obs() !== O_IDLE) begin errors++; $display("FAIL illegal_decode: state %0d out %b", state_o, obs()); end
    tick();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({state_o, trap, trap_cause} !== 6'b111_1_01 || obs() !== O_IDLE) begin
        errors++;
        $display("FAIL illegal_trap[%0d]: state %0d trap %0b cause %0d out %b exp 7/1/1/0", i, state_o, trap, trap_cause, obs());
      end
      tick();
    end
    rst = 1'b1; #1;
    vectors++;
    if ({state_o, trap, trap_cause} !== 6'b000_0_00 || instret !== 32'd0) begin
      errors++; $display("FAIL illegal_rst: state %0d trap %0b cause %0d instret %0d", state_o, trap, trap_cause, instret);
    end
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_timeout();
    instr = I_ADDI; mem_ready = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (state_o !== 3'd0 || obs() !== O_FW) begin errors++; $display("FAIL timeout_wait[%0d]: state %0d out %b", i, state_o, obs()); end
      tick();
    end
    #1;
    vectors++;
    if ({state_o, trap, trap_cause} !== 6'b111_1_10 || obs() !== O_IDLE) begin
      errors++; $display("FAIL timeout_trap: state %0d trap %0b cause %0d out %b exp 7/1/2", state_o, trap, trap_cause, obs());
    end
    tick();
    do_reset();
  endtask

  task automatic test_rst_mid_store();
    cyc_t q[$];
    q.push_back(row(I_SW, 1, 0, 0, O_F));
    q.push_back(row(I_SW, 1, 0, 1, O_IDLE));
    q.push_back(row(I_SW, 1, 0, 2, O_EX_B));
    q.push_back(row(I_SW, 0, 0, 3, O_MEM_SW_W));
    foreach (q[i]) begin
      instr = q[i].ins; mem_ready = q[i].rdy; br_taken = q[i].brt; #1;
      vectors++;
      if (state_o !== q[i].st) begin errors++; $display("FAIL rstmem_state[%0d]: got %0d exp %0d", i, state_o, q[i].st); end
      vectors++;
      if (obs() !== q[i].o) begin errors++; $display("FAIL rstmem_out[%0d]: got %b exp %b", i, obs(), q[i].o); end
      tick();
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if (mem_we !== 1'b1 || state_o !== 3'd3) begin errors++; $display("FAIL rstmem_pre: mem_we %0b state %0d", mem_we, state_o); end
    rst = 1'b1; #1;
    vectors++;
    if (obs() !== O_IDLE || state_o !== 3'd0) begin errors++; $display("FAIL rstmem_abort: out %b state %0d", obs(), state_o); end
    tick();
    rst = 1'b0; #1;
    vectors++;
    if (state_o !== 3'd0 || instret !== 32'd0 || obs() !== O_FW) begin
      errors++; $display("FAIL rstmem_release: state %0d instret %0d out %b", state_o, instret, obs());
    end
    exp_instret = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = 32'd0; br_taken = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_rst_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
